// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences a single CPU load/store against a word-wide
// memory with a ready handshake. Checks alignment, drives word-aligned
// address, byte enables and lane-replicated store data, waits for
// mem_ready (bounded by TIMEOUT) and returns extended load data.
// All outputs come straight from registers.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 32'd255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic        sign_ext_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ready_i
);

  // Counter only needs to reach TIMEOUT.
  localparam int CW = (TIMEOUT < 32'd2) ? 1 : $clog2(TIMEOUT + 32'd1);
  localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);
  localparam logic [CW-1:0] ONE_C     = CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [1:0]    size_q, size_d;
  logic          sext_q, sext_d;
  logic [1:0]    off_q, off_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [3:0]    mem_be_q, mem_be_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic [CW-1:0] cnt_inc_s;

  // Reserved size or a half/word access not on its natural boundary.
  function automatic logic is_bad(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    case (size)
      2'd0:    bad = 1'b0;
      2'd1:    bad = off[0];
      2'd2:    bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Byte-enable pattern for the addressed lanes.
  function automatic logic [3:0] be_gen(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      2'd0:    be = 4'b0001 << off;
      2'd1:    be = off[1] ? 4'b1100 : 4'b0011;
      2'd2:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicate right-justified store data across all lanes.
  function automatic logic [31:0] wdata_gen(input logic [1:0] size, input logic [31:0] wd);
    logic [31:0] r;
    case (size)
      2'd0:    r = {4{wd[7:0]}};
      2'd1:    r = {2{wd[15:0]}};
      default: r = wd;
    endcase
    return r;
  endfunction

  // Pick the addressed byte/half from the read word and extend it.
  function automatic logic [31:0] load_extend(input logic [31:0] rd, input logic [1:0] size,
                                              input logic [1:0] off, input logic sext);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = rd[{off, 3'b000} +: 8];
    h = rd[{off[1], 4'b0000} +: 16];
    case (size)
      2'd0:    r = {{24{sext & b[7]}}, b};
      2'd1:    r = {{16{sext & h[15]}}, h};
      default: r = rd;
    endcase
    return r;
  endfunction

  assign cnt_inc_s = cnt_q + ONE_C;

  // Next-state and next-output logic for the IDLE/ACCESS/RESP sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    size_d      = size_q;
    sext_d      = sext_q;
    off_d       = off_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    rdata_d     = rdata_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (req_i) begin
          we_d   = we_i;
          size_d = size_i;
          sext_d = sign_ext_i;
          off_d  = addr_i[1:0];
          busy_d = 1'b1;
          cnt_d  = '0;
          if (is_bad(size_i, addr_i[1:0])) begin
            // Rejected up front: never touches memory.
            state_d = ST_RESP;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d     = ST_ACCESS;
            mem_req_d   = 1'b1;
            mem_we_d    = we_i;
            mem_be_d    = be_gen(size_i, addr_i[1:0]);
            mem_addr_d  = {addr_i[31:2], 2'b00};
            mem_wdata_d = wdata_gen(size_i, wdata_i);
          end
        end else begin
          busy_d = 1'b0;
        end
      end

      ST_ACCESS: begin
        if (mem_ready_i) begin
          state_d   = ST_RESP;
          done_d    = 1'b1;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          mem_be_d  = 4'b0000;
          if (!we_q) begin
            rdata_d = load_extend(mem_rdata_i, size_q, off_q, sext_q);
          end else begin
            rdata_d = rdata_q;
          end
        end else if (cnt_inc_s == TIMEOUT_C) begin
          // Memory never answered: abandon the request and flag it.
          state_d   = ST_RESP;
          done_d    = 1'b1;
          err_d     = 1'b1;
          cnt_d     = cnt_inc_s;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          mem_be_d  = 4'b0000;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d   = ST_IDLE;
        busy_d    = 1'b0;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
        mem_be_d  = 4'b0000;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      size_q      <= 2'd0;
      sext_q      <= 1'b0;
      off_q       <= 2'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= 32'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= 4'b0000;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      size_q      <= size_d;
      sext_q      <= sext_d;
      off_q       <= off_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign rdata_o     = rdata_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_be_o    = mem_be_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a scoreboard of expected
// completion results (err, rdata) pushed at request time and popped on done.
module tb_mem_access_ctrl;

  localparam int unsigned TMO = 32'd16;

  logic        clk;
  logic        rst;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } exp_t;
  exp_t sb_q[$];

  logic [31:0] last_rd;

  mem_access_ctrl #(.TIMEOUT(TMO)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_i       (req),
    .we_i        (we),
    .size_i      (size),
    .sign_ext_i  (sign_ext),
    .addr_i      (addr),
    .wdata_i     (wdata),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err),
    .rdata_o     (rdata),
    .mem_req_o   (mem_req),
    .mem_we_o    (mem_we),
    .mem_be_o    (mem_be),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata),
    .mem_ready_i (mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: observed=no_finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // done must be high now; pop the scoreboard and compare err/rdata.
  task automatic expect_done(input string tag);
    exp_t e;
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    total++;
    assert (sb_q.size() != 0) else begin
      bad++;
      $error("FAIL %s_sb: observed=empty expected=entry", tag);
    end
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk({tag, "_err"},   {31'd0, err}, {31'd0, e.err});
      chk({tag, "_rdata"}, rdata, e.rdata);
    end else begin
      e.err = 1'b0;
    end
  endtask

  task automatic issue(input logic w, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic e_err, input logic [31:0] e_rd);
    exp_t e;
    e.err   = e_err;
    e.rdata = e_rd;
    sb_q.push_back(e);
    we       = w;
    size     = sz;
    sign_ext = sx;
    addr     = a;
    wdata    = wd;
    req      = 1'b1;
    step();
    req      = 1'b0;
  endtask

  // Successful access: checks request fields every wait cycle, then done.
  task automatic access(input string tag, input logic w, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] wd, input int waits,
                        input logic [31:0] rd, input logic [3:0] e_be,
                        input logic [31:0] e_addr, input logic [31:0] e_wd,
                        input logic [31:0] e_rd);
    issue(w, sz, sx, a, wd, 1'b0, e_rd);
    for (int i = 0; i <= waits; i++) begin
      chk({tag, "_mem_req"},   {31'd0, mem_req}, 32'd1);
      chk({tag, "_mem_we"},    {31'd0, mem_we}, {31'd0, w});
      chk({tag, "_mem_addr"},  mem_addr, e_addr);
      chk({tag, "_mem_be"},    {28'd0, mem_be}, {28'd0, e_be});
      chk({tag, "_mem_wdata"}, mem_wdata, e_wd);
      chk({tag, "_busy"},      {31'd0, busy}, 32'd1);
      chk({tag, "_early"},     {31'd0, done}, 32'd0);
      if (i == waits) begin
        mem_ready = 1'b1;
        mem_rdata = rd;
      end
      step();
      mem_ready = 1'b0;
      mem_rdata = 32'hDEAD_BEEF;
    end
    expect_done(tag);
    chk({tag, "_req_drop"}, {31'd0, mem_req}, 32'd0);
    chk({tag, "_busy_done"}, {31'd0, busy}, 32'd1);
    step();
    chk({tag, "_pulse"}, {31'd0, done}, 32'd0);
    chk({tag, "_idle"},  {31'd0, busy}, 32'd0);
    last_rd = e_rd;
  endtask

  // Rejected access: done+err one cycle after req, no memory request.
  task automatic reject(input string tag, input logic w, input logic [1:0] sz,
                        input logic [31:0] a);
    issue(w, sz, 1'b0, a, 32'h5555_AAAA, 1'b1, last_rd);
    expect_done(tag);
    chk({tag, "_no_req"}, {31'd0, mem_req}, 32'd0);
    step();
    chk({tag, "_pulse"},   {31'd0, done}, 32'd0);
    chk({tag, "_no_req2"}, {31'd0, mem_req}, 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    req       = 1'b0;
    we        = 1'b0;
    size      = 2'd0;
    sign_ext  = 1'b0;
    addr      = 32'd0;
    wdata     = 32'd0;
    mem_rdata = 32'd0;
    mem_ready = 1'b0;
    last_rd   = 32'd0;
    step();
    step();
    chk("rst_busy",    {31'd0, busy}, 32'd0);
    chk("rst_done",    {31'd0, done}, 32'd0);
    chk("rst_err",     {31'd0, err}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_we",  {31'd0, mem_we}, 32'd0);
    chk("rst_mem_be",  {28'd0, mem_be}, 32'd0);
    chk("rst_rdata",   rdata, 32'd0);
    chk("rst_addr",    mem_addr, 32'd0);
    chk("rst_wdata",   mem_wdata, 32'd0);
    rst = 1'b0;
    step();

    // lb 0x1003: top byte 0x80 sign-extended.
    access("lb", 1'b0, 2'd0, 1'b1, 32'h0000_1003, 32'd0, 0, 32'h80FF_1234,
           4'b1000, 32'h0000_1000, 32'd0, 32'hFFFF_FF80);
    // lhu / lh 0x2002: upper half 0x8001.
    access("lhu", 1'b0, 2'd1, 1'b0, 32'h0000_2002, 32'd0, 0, 32'h8001_0000,
           4'b1100, 32'h0000_2000, 32'd0, 32'h0000_8001);
    access("lh", 1'b0, 2'd1, 1'b1, 32'h0000_2002, 32'd0, 1, 32'h8001_0000,
           4'b1100, 32'h0000_2000, 32'd0, 32'hFFFF_8001);
    // sb 0x3001 after three waits: rdata untouched.
    access("sb", 1'b1, 2'd0, 1'b0, 32'h0000_3001, 32'h1234_56AB, 3, 32'h0BAD_0BAD,
           4'b0010, 32'h0000_3000, 32'hABAB_ABAB, 32'hFFFF_8001);
    // lbu byte 1, lb positive byte 2, lh lower half, lw ignoring sign_ext.
    access("lbu", 1'b0, 2'd0, 1'b0, 32'h0000_1001, 32'd0, 0, 32'h0000_F700,
           4'b0010, 32'h0000_1000, 32'd0, 32'h0000_00F7);
    access("lb_pos", 1'b0, 2'd0, 1'b1, 32'h0000_1002, 32'd0, 2, 32'hFF7F_0000,
           4'b0100, 32'h0000_1000, 32'd0, 32'h0000_007F);
    access("lh_lo", 1'b0, 2'd1, 1'b1, 32'h0000_2000, 32'd0, 0, 32'h1234_9ABC,
           4'b0011, 32'h0000_2000, 32'd0, 32'hFFFF_9ABC);
    access("lw", 1'b0, 2'd2, 1'b1, 32'h0000_2004, 32'd0, 0, 32'h8765_4321,
           4'b1111, 32'h0000_2004, 32'd0, 32'h8765_4321);
    access("sh", 1'b1, 2'd1, 1'b0, 32'h0000_2002, 32'h0000_BEEF, 0, 32'd0,
           4'b1100, 32'h0000_2000, 32'hBEEF_BEEF, 32'h8765_4321);
    access("sw", 1'b1, 2'd2, 1'b0, 32'h0000_3000, 32'h1122_3344, 1, 32'd0,
           4'b1111, 32'h0000_3000, 32'h1122_3344, 32'h8765_4321);

    // Error paths.
    reject("sw_mis", 1'b1, 2'd2, 32'h0000_4002);
    reject("size3",  1'b0, 2'd3, 32'h0000_4000);
    reject("lh_odd", 1'b0, 2'd1, 32'h0000_4001);

    // mem_ready while idle must not produce a completion.
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    chk("idle_ready_done", {31'd0, done}, 32'd0);
    chk("idle_ready_busy", {31'd0, busy}, 32'd0);

    // Timeout: mem_req cycles 1..TMO, done+err at TMO+1.
    issue(1'b0, 2'd2, 1'b0, 32'h0000_5000, 32'd0, 1'b1, last_rd);
    for (int i = 0; i < int'(TMO); i++) begin
      chk("tmo_mem_req", {31'd0, mem_req}, 32'd1);
      chk("tmo_early",   {31'd0, done}, 32'd0);
      step();
    end
    expect_done("tmo");
    chk("tmo_req_drop", {31'd0, mem_req}, 32'd0);
    step();
    chk("tmo_pulse", {31'd0, done}, 32'd0);

    // Reset in the middle of a pending lw.
    issue(1'b0, 2'd2, 1'b0, 32'h0000_0020, 32'd0, 1'b0, 32'd0);
    chk("rst_mid_req1", {31'd0, mem_req}, 32'd1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    void'(sb_q.pop_back());
    chk("rst_mid_req3", {31'd0, mem_req}, 32'd0);
    chk("rst_mid_done", {31'd0, done}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    step();
    chk("rst_mid_done2", {31'd0, done}, 32'd0);
    last_rd = 32'd0;
    access("lw_after", 1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'd0, 0, 32'hCAFE_F00D,
           4'b1111, 32'h0000_0010, 32'd0, 32'hCAFE_F00D);

    chk("sb_empty", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
